// File: rtl/fifo_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_tx_pkg
// Shared definitions for the FIFO-to-RIFFA TX packer:
//   - tx_state_e      : transaction FSM state encoding
//   - lanes_per_beat  : number of FIFO words packed into one RIFFA beat
//   - dwords_per_word : number of 32-bit dwords carried by one FIFO word
//   - ceil_div        : rounding-up division used to turn a dword length
//                       into a FIFO word count without overflowing
// ---------------------------------------------------------------------------
package fifo_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

    function automatic int unsigned lanes_per_beat(input int unsigned beat_w,
                                                   input int unsigned word_w);
        return beat_w / word_w;
    endfunction

    // Words narrower than a dword are not supported; clamp to 1 so the
    // divider below never sees zero.
    function automatic int unsigned dwords_per_word(input int unsigned word_w);
        return (word_w < 32) ? 1 : word_w / 32;
    endfunction

    // Quotient plus one when there is a remainder. Written this way rather
    // than (num + den - 1) / den so a length of all-ones cannot wrap.
    function automatic logic [63:0] ceil_div(input logic [63:0] num,
                                             input logic [63:0] den);
        logic [63:0] q;
        q = num / den;
        if ((num % den) != 64'd0) begin
            q = q + 64'd1;
        end
        return q;
    endfunction

endpackage

// File: rtl/tx_lane_packer.sv
// ---------------------------------------------------------------------------
// tx_lane_packer
// Collects WIDTH-bit FIFO words into C_PCI_DATA_WIDTH-bit beats and holds
// the finished beat in an output register until the consumer takes it.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   pop_i          : a FIFO pop is being issued this cycle
//   word_i         : FIFO read data (valid the cycle after pop_i)
//   word_last_i    : the word arriving this cycle is the final one
//   beat_ready_i   : consumer takes the output beat this cycle
//   can_pop_o      : there is room for another word in the pack register
//   word_vld_o     : a FIFO word arrives this cycle
//   beat_o         : packed beat, first word in the least significant lane
//   beat_valid_o   : beat_o holds an unconsumed beat
//   beat_last_o    : beat_o is the final beat of the transaction
// ---------------------------------------------------------------------------
module tx_lane_packer
    import fifo_tx_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int C_PCI_DATA_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        pop_i,
    input  logic [WIDTH-1:0]            word_i,
    input  logic                        word_last_i,
    input  logic                        beat_ready_i,
    output logic                        can_pop_o,
    output logic                        word_vld_o,
    output logic [C_PCI_DATA_WIDTH-1:0] beat_o,
    output logic                        beat_valid_o,
    output logic                        beat_last_o
);

    localparam int RATIO = int'(lanes_per_beat(C_PCI_DATA_WIDTH, WIDTH));
    // Must represent lane_cnt + inflight, i.e. up to RATIO + 1.
    localparam int CNT_W = $clog2(RATIO + 2);

    logic [C_PCI_DATA_WIDTH-1:0] pack_q, pack_d, pack_m;
    logic [CNT_W-1:0]            lane_cnt_q, lane_cnt_d, cnt_m;
    logic                        inflight_q;
    logic                        last_pend_q, last_pend_d, last_m;
    logic [C_PCI_DATA_WIDTH-1:0] beat_q, beat_d;
    logic                        beat_valid_q, beat_valid_d;
    logic                        beat_last_q, beat_last_d;
    logic                        out_free;
    logic                        flush;

    always_comb begin
        // Pack register as it looks once this cycle's word (if any) lands.
        pack_m = pack_q;
        if (inflight_q) begin
            for (int i = 0; i < RATIO; i++) begin
                if (lane_cnt_q == CNT_W'(i)) begin
                    pack_m[i*WIDTH +: WIDTH] = word_i;
                end
            end
        end
        cnt_m  = lane_cnt_q + CNT_W'(inflight_q);
        last_m = last_pend_q | (inflight_q & word_last_i);

        // A finished beat may only move forward when the output register
        // is empty or is being drained this very cycle. A full or final
        // beat that cannot move simply waits in the pack register; the
        // pop gate below keeps further words out until it does.
        out_free = !beat_valid_q || beat_ready_i;
        flush    = ((cnt_m == CNT_W'(RATIO)) || last_m) && (cnt_m != '0) && out_free;

        pack_d       = pack_m;
        lane_cnt_d   = cnt_m;
        last_pend_d  = last_m;
        beat_d       = beat_q;
        beat_valid_d = beat_valid_q && !beat_ready_i;
        beat_last_d  = beat_last_q;

        if (flush) begin
            beat_d       = pack_m;
            beat_valid_d = 1'b1;
            beat_last_d  = last_m;
            // Clearing here is what leaves unused upper lanes of a short
            // final beat at zero.
            pack_d       = '0;
            lane_cnt_d   = '0;
            last_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_q       <= '0;
            lane_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            last_pend_q  <= 1'b0;
            beat_q       <= '0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
        end else begin
            pack_q       <= pack_d;
            lane_cnt_q   <= lane_cnt_d;
            inflight_q   <= pop_i;
            last_pend_q  <= last_pend_d;
            beat_q       <= beat_d;
            beat_valid_q <= beat_valid_d;
            beat_last_q  <= beat_last_d;
        end
    end

    // Count the word still in the FIFO's output register as occupying a lane
    // so a pack register one short of full does not over-pop.
    assign can_pop_o    = (lane_cnt_q + CNT_W'(inflight_q)) < CNT_W'(RATIO);
    assign word_vld_o   = inflight_q;
    assign beat_o       = beat_q;
    assign beat_valid_o = beat_valid_q;
    assign beat_last_o  = beat_last_q;

endmodule

// File: rtl/fifo_tx_packer.sv
// ---------------------------------------------------------------------------
// fifo_tx_packer
// Drains the channel FIFO and sends its contents to the host as one RIFFA
// TX channel transaction per start request, packing WIDTH-bit FIFO words
// into C_PCI_DATA_WIDTH-bit beats. WIDTH must divide C_PCI_DATA_WIDTH.
//
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, tx_len        : request a transaction of tx_len dwords (IDLE only)
//   busy, done           : transaction in progress / one-cycle completion
//   fifo_pop             : FIFO pop, never asserted while fifo_empty
//   fifo_dout            : FIFO data, registered (valid the cycle after pop)
//   fifo_empty           : FIFO empty flag
//   CHNL_TX, CHNL_TX_ACK : RIFFA transaction request / host acceptance
//   CHNL_TX_LAST         : constant 1
//   CHNL_TX_LEN          : latched transaction length in dwords
//   CHNL_TX_OFF          : constant 0
//   CHNL_TX_DATA*        : beat, valid, and host read-enable
// ---------------------------------------------------------------------------
module fifo_tx_packer
    import fifo_tx_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int LEN_W            = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [LEN_W-1:0]            tx_len,
    output logic                        busy,
    output logic                        done,
    output logic                        fifo_pop,
    input  logic [WIDTH-1:0]            fifo_dout,
    input  logic                        fifo_empty,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN
);

    localparam int WPW = int'(dwords_per_word(WIDTH));

    tx_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pops_left_q, pops_left_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic [LEN_W-1:0] words_total;

    logic             can_pop;
    logic             word_vld;
    logic             word_last;
    logic             beat_valid;
    logic             beat_last;
    logic             beat_accept;

    assign words_total = LEN_W'(ceil_div(64'(tx_len), 64'(WPW)));

    // Pops only happen after the host has accepted the transaction.
    assign fifo_pop = (state_q == ST_XFER) && !fifo_empty &&
                      (pops_left_q != '0) && can_pop;

    // words_left counts words not yet returned by the FIFO, so the word
    // arriving while it reads 1 is the final one.
    assign word_last   = (words_left_q == LEN_W'(1));
    assign beat_accept = beat_valid && CHNL_TX_DATA_REN;

    tx_lane_packer #(
        .WIDTH            (WIDTH),
        .C_PCI_DATA_WIDTH (C_PCI_DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .pop_i        (fifo_pop),
        .word_i       (fifo_dout),
        .word_last_i  (word_last),
        .beat_ready_i (CHNL_TX_DATA_REN),
        .can_pop_o    (can_pop),
        .word_vld_o   (word_vld),
        .beat_o       (CHNL_TX_DATA),
        .beat_valid_o (beat_valid),
        .beat_last_o  (beat_last)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pops_left_d  = pops_left_q;
        words_left_d = words_left_q;

        case (state_q)
            ST_IDLE: begin
                // A zero-length request has nothing to send and is dropped.
                if (start && (tx_len != '0)) begin
                    len_d        = tx_len;
                    pops_left_d  = words_total;
                    words_left_d = words_total;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (CHNL_TX_ACK) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (fifo_pop) begin
                    pops_left_d = pops_left_q - LEN_W'(1);
                end
                if (word_vld) begin
                    words_left_d = words_left_q - LEN_W'(1);
                end
                if (beat_accept && beat_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            pops_left_q  <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pops_left_q  <= pops_left_d;
            words_left_q <= words_left_d;
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign CHNL_TX            = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_LEN        = 32'(len_q);
    assign CHNL_TX_DATA_VALID = beat_valid;

endmodule

// File: tb/tb_fifo_tx_packer.sv
`timescale 1ns/1ps
module tb_fifo_tx_packer;

    localparam int WIDTH = 32;
    localparam int DW    = 128;
    localparam int LEN_W = 32;
    localparam int RATIO = DW / WIDTH;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  tx_len;
    logic              busy;
    logic              done;
    logic              fifo_pop;
    logic [WIDTH-1:0]  fifo_dout = '0;
    logic              fifo_empty;
    logic              CHNL_TX;
    logic              CHNL_TX_ACK;
    logic              CHNL_TX_LAST;
    logic [31:0]       CHNL_TX_LEN;
    logic [30:0]       CHNL_TX_OFF;
    logic [DW-1:0]     CHNL_TX_DATA;
    logic              CHNL_TX_DATA_VALID;
    logic              CHNL_TX_DATA_REN;

    int checks   = 0;
    int failures = 0;

    fifo_tx_packer #(
        .WIDTH            (WIDTH),
        .C_PCI_DATA_WIDTH (DW),
        .LEN_W            (LEN_W)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .tx_len             (tx_len),
        .busy               (busy),
        .done               (done),
        .fifo_pop           (fifo_pop),
        .fifo_dout          (fifo_dout),
        .fifo_empty         (fifo_empty),
        .CHNL_TX            (CHNL_TX),
        .CHNL_TX_ACK        (CHNL_TX_ACK),
        .CHNL_TX_LAST       (CHNL_TX_LAST),
        .CHNL_TX_LEN        (CHNL_TX_LEN),
        .CHNL_TX_OFF        (CHNL_TX_OFF),
        .CHNL_TX_DATA       (CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN   (CHNL_TX_DATA_REN)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, pops against an empty FIFO are logged.
    logic [WIDTH-1:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int pop_empty_errs = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_pop) begin
            if (fifo_empty) begin
                pop_empty_errs <= pop_empty_errs + 1;
            end else begin
                fifo_dout <= mem[rd_ptr[11:0]];
                rd_ptr    <= rd_ptr + 1;
                pop_cnt   <= pop_cnt + 1;
            end
        end
    end

    // Host-side monitor: records consumed beats, stability while stalled,
    // done pulses and transaction requests.
    logic [DW-1:0] beats [0:255];
    int nbeats = 0;
    int ndone = 0;
    int ntx_rise = 0;
    int stable_errs = 0;
    logic hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic tx_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_q  <= 1'b0;
            tx_prev <= 1'b0;
        end else begin
            if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
                beats[nbeats[7:0]] <= CHNL_TX_DATA;
                nbeats <= nbeats + 1;
            end
            if (hold_q && (!CHNL_TX_DATA_VALID || (CHNL_TX_DATA !== hold_data))) begin
                stable_errs <= stable_errs + 1;
            end
            hold_q    <= CHNL_TX_DATA_VALID && !CHNL_TX_DATA_REN;
            hold_data <= CHNL_TX_DATA;
            if (done) ndone <= ndone + 1;
            if (CHNL_TX && !tx_prev) ntx_rise <= ntx_rise + 1;
            tx_prev <= CHNL_TX;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        mem[wr_ptr[11:0]] = w;
        wr_ptr++;
    endtask

    logic [WIDTH-1:0] wbuf [0:63];

    // One full transaction. The words sent are the next len entries of the
    // FIFO; the bench's expectation is those words grouped RATIO at a time,
    // lowest lane first, zero padded.
    task automatic do_txn(input string tag, input int len, input int ack_dly,
                          input int stall, input bit ren_rand, input int n_late,
                          input int refill_at, input bit poke_busy);
        int base, b0, p0, d0, t0, nb, stall_cnt, snap, idx;
        bit finished, saw_valid, stall_done, refilled;
        logic [DW-1:0] expb;
        base = rd_ptr; b0 = nbeats; p0 = pop_cnt; d0 = ndone; t0 = ntx_rise;
        for (int i = 0; i < len - n_late; i++) push(wbuf[i]);
        CHNL_TX_DATA_REN = (stall == 0);
        start = 1'b1; tx_len = LEN_W'(len);
        tick();
        start = 1'b0; tx_len = '0;
        chk1({tag, ".busy"}, busy, 1'b1);
        chk1({tag, ".tx_req"}, CHNL_TX, 1'b1);
        chki({tag, ".len"}, CHNL_TX_LEN, 32'(len));
        for (int i = 0; i < ack_dly; i++) begin
            if (poke_busy && i == 0) begin
                start = 1'b1; tx_len = LEN_W'(3);
            end
            tick();
            start = 1'b0; tx_len = '0;
        end
        chki({tag, ".no_pop_before_ack"}, 32'(pop_cnt - p0), 32'd0);
        CHNL_TX_ACK = 1'b1;
        tick();
        CHNL_TX_ACK = 1'b0;

        finished = 1'b0; saw_valid = 1'b0; stall_cnt = 0; snap = 0;
        stall_done = (stall == 0); refilled = (n_late == 0);
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (done) begin
                finished = 1'b1;
            end else begin
                if (!refilled && cyc == refill_at) begin
                    chk1({tag, ".valid_while_empty"}, saw_valid, 1'b0);
                    for (int i = len - n_late; i < len; i++) push(wbuf[i]);
                    refilled = 1'b1;
                end
                if (CHNL_TX_DATA_VALID) saw_valid = 1'b1;
                if (!stall_done) begin
                    CHNL_TX_DATA_REN = 1'b0;
                    if (CHNL_TX_DATA_VALID) begin
                        if (stall_cnt == 0) snap = pop_cnt;
                        stall_cnt++;
                    end
                    if (stall_cnt == stall && stall_cnt != 0) begin
                        chk1({tag, ".stall_pops_le4"}, (pop_cnt - snap) <= 4, 1'b1);
                        stall_done = 1'b1;
                        CHNL_TX_DATA_REN = 1'b1;
                    end
                end else if (ren_rand) begin
                    CHNL_TX_DATA_REN = ($urandom_range(0, 3) != 0);
                end else begin
                    CHNL_TX_DATA_REN = 1'b1;
                end
                tick();
            end
        end
        chk1({tag, ".completed"}, finished, 1'b1);
        chk1({tag, ".busy_in_done"}, busy, 1'b1);
        chk1({tag, ".tx_low_in_done"}, CHNL_TX, 1'b0);
        chki({tag, ".pops"}, 32'(pop_cnt - p0), 32'(len));
        tick();
        chk1({tag, ".busy_drop"}, busy, 1'b0);
        chk1({tag, ".done_one_cycle"}, done, 1'b0);
        chki({tag, ".done_count"}, 32'(ndone - d0), 32'd1);
        chki({tag, ".tx_count"}, 32'(ntx_rise - t0), 32'd1);
        nb = (len + RATIO - 1) / RATIO;
        chki({tag, ".beats"}, 32'(nbeats - b0), 32'(nb));
        for (int k = 0; k < nb; k++) begin
            expb = '0;
            for (int j = 0; j < RATIO; j++) begin
                idx = k * RATIO + j;
                if (idx < len) begin
                    idx = base + idx;
                    expb = expb | (DW'(mem[idx[11:0]]) << (WIDTH * j));
                end
            end
            idx = b0 + k;
            chkw($sformatf("%s.beat%0d", tag, k), beats[idx[7:0]], expb);
        end
        CHNL_TX_DATA_REN = 1'b1;
    endtask

    initial begin
        int len, b0, t0, d0, bi;
        bit got;
        reset_n = 1'b0; start = 1'b0; tx_len = '0;
        CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b1;
        #1;
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.done", done, 1'b0);
        chk1("rst.pop", fifo_pop, 1'b0);
        chk1("rst.tx", CHNL_TX, 1'b0);
        chk1("rst.valid", CHNL_TX_DATA_VALID, 1'b0);
        chkw("rst.data", CHNL_TX_DATA, '0);
        chki("rst.len", CHNL_TX_LEN, 32'd0);
        chk1("rst.last", CHNL_TX_LAST, 1'b1);
        chki("rst.off", 32'(CHNL_TX_OFF), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Eight words, host acknowledges three cycles after the request.
        for (int i = 0; i < 8; i++) wbuf[i] = WIDTH'(i + 1);
        do_txn("t8", 8, 3, 0, 1'b0, 0, 0, 1'b0);
        bi = nbeats - 2;
        chkw("t8.first_beat", beats[bi[7:0]], 128'h00000004_00000003_00000002_00000001);
        bi = nbeats - 1;
        chkw("t8.second_beat", beats[bi[7:0]], 128'h00000008_00000007_00000006_00000005);

        // Five words: the final beat carries a single word in lane 0.
        for (int i = 0; i < 5; i++) wbuf[i] = WIDTH'(32'hA + i);
        do_txn("t5", 5, 1, 0, 1'b0, 0, 0, 1'b0);
        bi = nbeats - 1;
        chkw("t5.tail_beat", beats[bi[7:0]], 128'h00000000_00000000_00000000_0000000E);

        // Host holds off the first beat for ten cycles.
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        do_txn("stall", 8, 2, 10, 1'b0, 0, 0, 1'b0);

        // FIFO runs dry after two words and is refilled twenty cycles later.
        for (int i = 0; i < 4; i++) wbuf[i] = WIDTH'(i + 1);
        do_txn("empty", 4, 1, 0, 1'b0, 2, 20, 1'b0);

        // Zero-length start is dropped.
        t0 = ntx_rise; d0 = ndone;
        start = 1'b1; tx_len = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk1("len0.busy", busy, 1'b0);
        chk1("len0.tx", CHNL_TX, 1'b0);
        chki("len0.no_done", 32'(ndone - d0), 32'd0);
        chki("len0.no_tx", 32'(ntx_rise - t0), 32'd0);

        // Start while busy is ignored; acknowledge outside REQ is ignored.
        for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
        do_txn("poke", 6, 2, 0, 1'b0, 0, 0, 1'b1);
        t0 = ntx_rise;
        CHNL_TX_ACK = 1'b1;
        tick();
        CHNL_TX_ACK = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk1("poke.idle_busy", busy, 1'b0);
        chk1("poke.idle_tx", CHNL_TX, 1'b0);
        chki("poke.no_extra_tx", 32'(ntx_rise - t0), 32'd0);

        // Randomized transactions with a randomly throttled host.
        for (int t = 0; t < 6; t++) begin
            len = int'($urandom_range(1, 13));
            for (int i = 0; i < len; i++) wbuf[i] = $urandom;
            do_txn($sformatf("rnd%0d", t), len, int'($urandom_range(0, 4)), 0, 1'b1, 0, 0, 1'b0);
        end

        // Reset pulled in the middle of a transaction after the first beat.
        for (int i = 0; i < 8; i++) push(WIDTH'(32'h100 + i));
        b0 = nbeats;
        CHNL_TX_DATA_REN = 1'b1;
        start = 1'b1; tx_len = LEN_W'(8);
        tick();
        start = 1'b0;
        CHNL_TX_ACK = 1'b1;
        tick();
        CHNL_TX_ACK = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            if (nbeats - b0 >= 1) got = 1'b1;
            else tick();
        end
        chk1("abort.first_beat_seen", got, 1'b1);
        chk1("abort.busy_before", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("abort.busy", busy, 1'b0);
        chk1("abort.tx", CHNL_TX, 1'b0);
        chk1("abort.pop", fifo_pop, 1'b0);
        chk1("abort.valid", CHNL_TX_DATA_VALID, 1'b0);
        chkw("abort.data", CHNL_TX_DATA, '0);
        chki("abort.len", CHNL_TX_LEN, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) wbuf[i] = WIDTH'(32'h200 + i);
        do_txn("after_rst", 4, 1, 0, 1'b0, 0, 0, 1'b0);

        chki("no_pop_when_empty", 32'(pop_empty_errs), 32'd0);
        chki("beat_stable_while_stalled", 32'(stable_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
